// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory controller: FSM state encoding,
// load/store size encoding and the default I/O address selector.
package mem_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRead   = 3'd1,
      StWrite  = 3'd2,
      StIoWait = 3'd3,
      StDone   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      Size1B = 2'd0,
      Size2B = 2'd1,
      Size4B = 2'd2
   } size_e;

   // addr[17:16] value that marks the I/O region
   localparam logic [1:0] IoSelDefault = 2'b11;

   // Number of bytes moved for a given size code; the unused code is treated as a word
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         Size1B:  return 3'd1;
         Size2B:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller arbitrating an instruction-fetch word reader and a
// load/store unit onto a single 8-bit RAM/IO bus.
// Optional feature: define MEM_CTRL_IO_WAIT_EN to stall I/O writes while the UART
// transmit buffer reports full.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [1:0]  IO_SEL     = IoSelDefault
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  if_req_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   output logic                  if_done_out,
   output logic [31:0]           if_data_out,
   input  logic                  ls_req_in,
   input  logic                  ls_wr_in,
   input  logic [1:0]            ls_size_in,
   input  logic [ADDR_WIDTH-1:0] ls_addr_in,
   input  logic [31:0]           ls_wdata_in,
   output logic                  ls_done_out,
   output logic [31:0]           ls_rdata_out,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [31:0]           mem_a,
   output logic                  mem_wr,
   input  logic                  io_buffer_full
);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        is_ls_q, is_ls_d;

   logic [31:0] cur_addr;
   logic [31:0] hold_addr;
   logic        write_ok;
   logic        done;

   assign cur_addr  = base_q + {29'd0, cnt_q};
   // While frozen in READ, re-present the previous byte address so a synchronous
   // RAM keeps returning the byte that is still waiting to be captured.
   assign hold_addr = cur_addr - {31'd0, (cnt_q != 3'd0)};

`ifdef MEM_CTRL_IO_WAIT_EN
   assign write_ok = !((cur_addr[17:16] == IO_SEL) && io_buffer_full);
`else
   assign write_ok = 1'b1;
`endif

   assign done         = (state_q == StDone) && rdy_in;
   assign ls_done_out  = done && is_ls_q;
   assign if_done_out  = done && !is_ls_q;
   assign ls_rdata_out = ls_done_out ? data_q : 32'd0;
   assign if_data_out  = if_done_out ? data_q : 32'd0;

   // Next-state, byte counter, read assembly and bus drive
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      base_d   = base_q;
      wdata_d  = wdata_q;
      data_d   = data_q;
      is_ls_d  = is_ls_q;
      mem_a    = 32'd0;
      mem_dout = 8'd0;
      mem_wr   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A flush coinciding with a request suppresses the grant
            if (!flush_in) begin
               if (ls_req_in) begin
                  base_d  = 32'(ls_addr_in);
                  len_d   = size_bytes(ls_size_in);
                  wdata_d = ls_wdata_in;
                  is_ls_d = 1'b1;
                  cnt_d   = 3'd0;
                  data_d  = 32'd0;
                  state_d = ls_wr_in ? StWrite : StRead;
               end else if (if_req_in) begin
                  base_d  = 32'(if_addr_in);
                  len_d   = 3'd4;
                  wdata_d = 32'd0;
                  is_ls_d = 1'b0;
                  cnt_d   = 3'd0;
                  data_d  = 32'd0;
                  state_d = StRead;
               end
            end
         end

         StRead: begin
            if (!rdy_in) begin
               mem_a = hold_addr;
            end else if (cnt_q < len_q) begin
               mem_a = cur_addr;
            end
            // Byte k arrives the cycle after its address; cnt 4 maps to lane 3
            if (cnt_q != 3'd0) begin
               data_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
            end
            cnt_d = cnt_q + 3'd1;
            if (flush_in) begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else if (cnt_q == len_q) begin
               state_d = StDone;
               cnt_d   = 3'd0;
            end
         end

         StWrite: begin
            if (!write_ok) begin
               state_d = StIoWait;
            end else begin
               mem_a    = cur_addr;
               mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
               mem_wr   = rdy_in;
               cnt_d    = cnt_q + 3'd1;
               if (cnt_q == len_q - 3'd1) begin
                  state_d = StDone;
                  cnt_d   = 3'd0;
               end
            end
         end

         // The cycle that sees the buffer drain is the extra settle cycle
         StIoWait: begin
            if (!io_buffer_full) begin
               state_d = StWrite;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and latch registers; rdy_in low freezes everything
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         len_q   <= 3'd0;
         base_q  <= 32'd0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         is_ls_q <= 1'b0;
      end else if (rdy_in) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         is_ls_q <= is_ls_d;
      end
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of all address ports.
REQ-002 SHALL have parameter IO_SEL, default 2'b11, value of addr[17:16] that marks an I/O address.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes the block.
REQ-006 SHALL have port flush_in  input  1  pipeline flush (branch mispredict).
REQ-007 SHALL have ports if_req_in (input, 1), if_addr_in (input, ADDR_WIDTH), if_done_out (output, 1) and if_data_out (output, 32): word read requester (instruction fetch / icache miss).
REQ-008 SHALL have ports ls_req_in (input, 1), ls_wr_in (input, 1), ls_size_in (input, 2; 0=1B, 1=2B, 2=4B), ls_addr_in (input, ADDR_WIDTH), ls_wdata_in (input, 32), ls_done_out (output, 1) and ls_rdata_out (output, 32): load/store requester.
REQ-009 SHALL have ports mem_din (input, 8), mem_dout (output, 8), mem_a (output, 32) and mem_wr (output, 1; 1=write): the byte-wide RAM/IO bus.
REQ-010 SHALL have port io_buffer_full  input  1  UART transmit buffer full.

Function
REQ-011 SHALL implement FSM states IDLE, READ, WRITE, IO_WAIT and DONE.
REQ-012 SHALL arbitrate only in IDLE: ls_req_in wins over if_req_in, and a granted transfer runs to completion with no preemption.
REQ-013 SHALL latch the address, size, write data and requester at grant; request inputs are ignored until the next IDLE.
REQ-014 SHALL, in READ, drive mem_a=base+k and mem_wr=0 for k=0..N-1 on consecutive cycles.
REQ-015 SHALL capture mem_din one cycle after each address as byte k, little-endian.
REQ-016 SHALL, in WRITE, drive mem_a=base+k, mem_dout=byte k and mem_wr=1 for one cycle per byte.
REQ-017 SHALL meet latency measured from cycle C0, in which the request is sampled in IDLE: reads assert done in C0+N+2, writes assert done in C0+N+1.
REQ-018 SHALL, in DONE, pulse the granted requester's done output high for exactly one cycle with data valid, and return to IDLE without arbitrating in that cycle.
REQ-019 SHALL require each requester to deassert or change its request on the edge where it sees done.
REQ-020 SHALL zero-extend reads narrower than 4 bytes on ls_rdata_out; sign extension is outside this block.
REQ-021 SHALL return if_data_out and ls_rdata_out at 0 except in the DONE cycle of their own transfer.
REQ-022 SHALL wrap address arithmetic modulo 2^32.
REQ-023 SHALL, when flush_in is high in READ, abort the read, drive mem_wr=0, go to IDLE next cycle and issue no done.
REQ-024 SHALL not abort a WRITE on flush_in, since stores are committed.
REQ-025 SHALL ignore flush_in asserted in IDLE together with a request, with no grant that cycle.
REQ-026 SHALL, while rdy_in is low, hold all state, counters and latched data, force mem_wr=0 and suppress done pulses.
REQ-027 SHALL hold mem_a, mem_dout and mem_wr at 0 in IDLE, DONE and IO_WAIT.

Reset
REQ-028 SHALL, on rst_n_in low, immediately force state IDLE, counter 0, all latches 0, all outputs 0 and no pending done, independent of clk_in.
REQ-029 SHALL drop any in-flight transfer when reset is asserted mid-transfer, and SHALL NOT replay it after reset.

Configuration
REQ-030 SHALL, with MEM_CTRL_IO_WAIT_EN defined, stall in IO_WAIT before each WRITE byte to an I/O address while io_buffer_full is high, then spend one extra IO_WAIT cycle after it falls before writing.
REQ-031 SHALL, without MEM_CTRL_IO_WAIT_EN, ignore io_buffer_full and never enter IO_WAIT.

Structure
REQ-032 SHALL place the FSM state encoding, the ls_size_in encoding and the IO_SEL default in shared package mem_pkg.
REQ-033 SHALL be one module with no sub-modules; the byte counter and shift-assembly stay inline.

Verification
REQ-034 SHALL cover the IF word read: if_addr_in=0x100 with RAM bytes 13,05,00,00 -> if_done_out in C0+6 with if_data_out=0x00000513.
REQ-035 SHALL cover simultaneous requests: if_req_in and ls_req_in (1B read at 0x200 of byte 0xFF) in the same cycle -> ls_done_out in C0+3 with 0x000000FF, then the IF read is granted 1 cycle after DONE.
REQ-036 SHALL cover the 2B store: ls_wdata_in=0xBEEF at 0x10 -> mem_wr=1 with 0x10/0xEF then 0x11/0xBE, then ls_done_out in C0+3.
REQ-037 SHALL cover the IO write stall: with MEM_CTRL_IO_WAIT_EN, a 1B write to 0x30000 while io_buffer_full is high for 5 cycles -> no mem_wr during the stall, then exactly one write of the byte.
REQ-038 SHALL cover flush mid-read: flush_in in the 2nd address cycle of a 4B IF read -> no if_done_out, IDLE next cycle, and the next request is served normally.
REQ-039 SHALL cover rdy_in low for 3 cycles mid 4B read -> done delayed by exactly 3 cycles and data unchanged.
